// File: rtl/j1_io_bus_ctrl_if.sv
// J1 I/O bus bundle: CPU strobes/address/data plus the per-slot peripheral
// chip selects, read data and acks. The environment (CPU and peripherals)
// uses the master view; the bus controller uses the slave view.
interface j1_io_bus_ctrl_if #(
    parameter int NSLOTS = 8
);
    logic                   io_rd;
    logic                   io_wr;
    logic [15:0]            io_addr;
    logic [15:0]            io_dout;
    logic [15:0]            io_din;
    logic                   io_wait;
    logic [NSLOTS-1:0]      cs;
    logic [16*NSLOTS-1:0]   slv_dout;
    logic [NSLOTS-1:0]      slv_ack;

    modport master (
        output io_rd, io_wr, io_addr, io_dout, slv_dout, slv_ack,
        input  io_din, io_wait, cs
    );

    modport slave (
        input  io_rd, io_wr, io_addr, io_dout, slv_dout, slv_ack,
        output io_din, io_wait, cs
    );
endinterface

// File: rtl/j1_io_bus_ctrl.sv
// J1 I/O bus controller: decodes the CPU I/O page to one-hot slot selects,
// stalls the CPU for wait-state peripherals, aborts hung accesses after
// TIMEOUT cycles and keeps a small CPU-readable error status page.
module j1_io_bus_ctrl #(
    parameter int          NSLOTS     = 8,
    parameter logic [7:0]  BASE_HI    = 8'h67,
    parameter logic [7:0]  STATUS_HI  = 8'h7F,
    parameter logic [15:0] DEFAULT_RD = 16'h0666,
    parameter int          TIMEOUT    = 15
) (
    input  logic            sys_clk_i,
    input  logic            sys_rst_i,
    j1_io_bus_ctrl_if.slave bus
);

    localparam logic [7:0] NSLOTS8      = 8'(NSLOTS);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  waitCnt_q, waitCnt_d;
    logic [3:0]  slot_q, slot_d;
    logic [15:0] addr_q, addr_d;
    logic [1:0]  errFlags_q, errFlags_d;
    logic [15:0] errAddr_q, errAddr_d;
    logic [7:0]  toCount_q, toCount_d;

    logic [7:0]        page;
    logic [7:0]        offset;
    logic              req;
    logic              hit;
    logic              isStatus;
    logic [3:0]        selIdx;
    logic              selAck;
    logic [15:0]       selData;
    logic [NSLOTS-1:0] selOneHot;
    logic              unusedBits;

    assign page     = bus.io_addr[15:8];
    assign offset   = page - BASE_HI;
    assign req      = bus.io_rd | bus.io_wr;
    assign hit      = (page >= BASE_HI) && (offset < NSLOTS8);
    assign isStatus = (page == STATUS_HI);
    // While stalled the latched slot is used so a wandering io_addr cannot move the select
    assign selIdx   = (state_q == ST_WAIT) ? slot_q : offset[3:0];
    assign unusedBits = ^{bus.io_addr[7:2], bus.io_addr[0], bus.io_dout[14:2]};

    // Pick the ack, read data and chip select of the slot currently addressed
    always_comb begin
        selAck    = 1'b0;
        selData   = '0;
        selOneHot = '0;
        for (int k = 0; k < NSLOTS; k++) begin
            if (selIdx == 4'(k)) begin
                selAck       = bus.slv_ack[k];
                selData      = bus.slv_dout[16*k +: 16];
                selOneHot[k] = 1'b1;
            end
        end
    end

    // Access FSM: decode, stall/timeout handling and status register updates
    always_comb begin
        state_d     = state_q;
        waitCnt_d   = waitCnt_q;
        slot_d      = slot_q;
        addr_d      = addr_q;
        errFlags_d  = errFlags_q;
        errAddr_d   = errAddr_q;
        toCount_d   = toCount_q;
        bus.cs      = '0;
        bus.io_wait = 1'b0;
        bus.io_din  = DEFAULT_RD;
        if (!sys_rst_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (req && hit) begin
                        bus.cs = selOneHot;
                        if (selAck) begin
                            bus.io_din = selData;
                        end else begin
                            bus.io_wait = 1'b1;
                            slot_d      = offset[3:0];
                            addr_d      = bus.io_addr;
                            waitCnt_d   = '0;
                            state_d     = ST_WAIT;
                        end
                    end else if (req && isStatus) begin
                        if (bus.io_rd) begin
                            bus.io_din = bus.io_addr[1] ? errAddr_q
                                                        : {toCount_q, 6'b0, errFlags_q};
                        end
                        if (bus.io_wr && !bus.io_addr[1]) begin
                            errFlags_d = errFlags_q & ~bus.io_dout[1:0];
                            if (bus.io_dout[15]) begin
                                toCount_d = '0;
                            end
                        end
                    end else if (req) begin
                        errFlags_d[0] = 1'b1;
                        if (errFlags_q == 2'b00) begin
                            errAddr_d = bus.io_addr;
                        end
                    end
                end
                ST_WAIT: begin
                    bus.cs = selOneHot;
                    if (selAck) begin
                        bus.io_din = selData;
                        state_d    = ST_IDLE;
                    end else if (waitCnt_q == TIMEOUT_LAST) begin
                        state_d       = ST_IDLE;
                        errFlags_d[1] = 1'b1;
                        if (toCount_q != 8'hFF) begin
                            toCount_d = toCount_q + 8'd1;
                        end
                        if (errFlags_q == 2'b00) begin
                            errAddr_d = addr_q;
                        end
                    end else begin
                        bus.io_wait = 1'b1;
                        waitCnt_d   = waitCnt_q + 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and status registers with synchronous reset
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q    <= ST_IDLE;
            waitCnt_q  <= '0;
            slot_q     <= '0;
            addr_q     <= '0;
            errFlags_q <= '0;
            errAddr_q  <= '0;
            toCount_q  <= '0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            slot_q     <= slot_d;
            addr_q     <= addr_d;
            errFlags_q <= errFlags_d;
            errAddr_q  <= errAddr_d;
            toCount_q  <= toCount_d;
        end
    end

endmodule
